// File: rtl/uart_rx_ctrl_if.sv
// Signal bundle between the UART receive controller and its sampler,
// deserializer and check blocks; names match the original port list.
interface uart_rx_ctrl_if;
  logic       RX_IN;
  logic       PAR_EN;
  logic [5:0] Prescale;
  logic       strt_glitch;
  logic       par_err;
  logic       stp_err;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       dat_samp_en;
  logic       deser_en;
  logic       strt_chk_en;
  logic       par_chk_en;
  logic       stp_chk_en;
  logic       data_valid;
  logic       frm_err;

  modport master (
    output RX_IN, PAR_EN, Prescale, strt_glitch, par_err, stp_err,
    input  edge_cnt, bit_cnt, dat_samp_en, deser_en, strt_chk_en,
           par_chk_en, stp_chk_en, data_valid, frm_err
  );

  modport slave (
    input  RX_IN, PAR_EN, Prescale, strt_glitch, par_err, stp_err,
    output edge_cnt, bit_cnt, dat_samp_en, deser_en, strt_chk_en,
           par_chk_en, stp_chk_en, data_valid, frm_err
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive frame controller: tracks oversample edge and bit position,
// strobes the check/shift blocks and reports good or dropped frames.
module uart_rx_ctrl (
  input  logic          CLK,
  input  logic          RST,
  uart_rx_ctrl_if.slave ctrl
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t     state_q, state_d;
  logic [5:0] edge_q, edge_d;
  logic [3:0] bit_q, bit_d;
  logic [5:0] p_q, p_d;
  logic       par_en_q, par_en_d;
  logic       dv_q, dv_d;
  logic       fe_q, fe_d;
  logic       samp, last;
  logic       strt_en, deser, par_en_chk, stp_en;

  assign samp = (edge_q == p_q - 6'd2);
  assign last = (edge_q == p_q - 6'd1);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= IDLE;
      edge_q   <= '0;
      bit_q    <= '0;
      p_q      <= 6'd8;
      par_en_q <= 1'b0;
      dv_q     <= 1'b0;
      fe_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      edge_q   <= edge_d;
      bit_q    <= bit_d;
      p_q      <= p_d;
      par_en_q <= par_en_d;
      dv_q     <= dv_d;
      fe_q     <= fe_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    edge_d     = edge_q;
    bit_d      = bit_q;
    p_d        = p_q;
    par_en_d   = par_en_q;
    dv_d       = 1'b0;
    fe_d       = 1'b0;
    strt_en    = 1'b0;
    deser      = 1'b0;
    par_en_chk = 1'b0;
    stp_en     = 1'b0;

    if (state_q != IDLE) begin
      edge_d = last ? '0 : edge_q + 6'd1;
      bit_d  = last ? bit_q + 4'd1 : bit_q;
    end

    case (state_q)
      IDLE: begin
        if (!ctrl.RX_IN) begin
          state_d  = START;
          par_en_d = ctrl.PAR_EN;
          // Anything other than 16 or 32 runs at the default ratio of 8.
          p_d      = (ctrl.Prescale == 6'd16 || ctrl.Prescale == 6'd32) ?
                     ctrl.Prescale : 6'd8;
        end
      end
      START: begin
        strt_en = samp;
        if (last) begin
          if (ctrl.strt_glitch) begin
            state_d = IDLE;
            fe_d    = 1'b1;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        deser = samp;
        if (last && bit_q == 4'd8) state_d = par_en_q ? PARITY : STOP;
      end
      PARITY: begin
        par_en_chk = samp;
        if (last) begin
          if (ctrl.par_err) begin
            state_d = IDLE;
            fe_d    = 1'b1;
          end else begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        stp_en = samp;
        if (last) begin
          state_d = IDLE;
          fe_d    = ctrl.stp_err;
          dv_d    = !ctrl.stp_err;
        end
      end
      default: state_d = IDLE;
    endcase

    // Counters sit at zero throughout IDLE, including the cycle after an exit.
    if (state_q == IDLE || state_d == IDLE) begin
      edge_d = '0;
      bit_d  = '0;
    end
  end

  assign ctrl.edge_cnt    = edge_q;
  assign ctrl.bit_cnt     = bit_q;
  assign ctrl.dat_samp_en = (state_q != IDLE);
  assign ctrl.strt_chk_en = strt_en;
  assign ctrl.deser_en    = deser;
  assign ctrl.par_chk_en  = par_en_chk;
  assign ctrl.stp_chk_en  = stp_en;
  assign ctrl.data_valid  = dv_q;
  assign ctrl.frm_err     = fe_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Randomized scoreboard bench for uart_rx_ctrl: expected strobe/result events
// are computed per frame from the frame timing rules and checked as they occur.
module tb_uart_rx_ctrl;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  uart_rx_ctrl_if bus ();

  uart_rx_ctrl dut (
    .CLK  (CLK),
    .RST  (RST),
    .ctrl (bus)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // kind: 0 strt_chk, 1 deser, 2 par_chk, 3 stp_chk, 4 data_valid, 5 frm_err
  typedef struct {
    int cyc;
    int kind;
    int edge_v;
    int bit_v;
    int samp;
  } ev_t;

  ev_t sb[$];

  task automatic push(input int c, input int k, input int e, input int b, input int s);
    ev_t ev;
    ev.cyc = c; ev.kind = k; ev.edge_v = e; ev.bit_v = b; ev.samp = s;
    sb.push_back(ev);
  endtask

  // Monitor: every asserted strobe/result must match the oldest expected event.
  always @(negedge CLK) begin
    logic [5:0] act;
    act = {bus.frm_err, bus.data_valid, bus.stp_chk_en,
           bus.par_chk_en, bus.deser_en, bus.strt_chk_en};
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      n_cmp++;
      n_bad++;
      $display("FAIL missed_event: got nothing by cyc=%0d, want kind=%0d at cyc=%0d",
               cyc, sb[0].kind, sb[0].cyc);
      void'(sb.pop_front());
    end
    for (int k = 0; k < 6; k++) begin
      if (act[k]) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_event: got kind=%0d at cyc=%0d, want no event",
                   k, cyc);
        end else begin
          ev_t w;
          w = sb.pop_front();
          if (w.kind != k || w.cyc != cyc || w.edge_v != int'(bus.edge_cnt) ||
              w.bit_v != int'(bus.bit_cnt) || w.samp != int'(bus.dat_samp_en)) begin
            n_bad++;
            $display("FAIL event: got kind=%0d cyc=%0d edge=%0d bit=%0d samp=%0d, want kind=%0d cyc=%0d edge=%0d bit=%0d samp=%0d",
                     k, cyc, bus.edge_cnt, bus.bit_cnt, bus.dat_samp_en,
                     w.kind, w.cyc, w.edge_v, w.bit_v, w.samp);
          end
        end
      end
    end
  end

  task automatic check_quiet(input string name);
    logic [17:0] got;
    got = {bus.edge_cnt, bus.bit_cnt, bus.dat_samp_en, bus.deser_en, bus.strt_chk_en,
           bus.par_chk_en, bus.stp_chk_en, bus.data_valid, bus.frm_err};
    n_cmp++;
    if (got != '0) begin
      n_bad++;
      $display("FAIL %s: got outputs=%h, want all zero", name, got);
    end
  endtask

  task automatic noise();
    bus.strt_glitch = 1'($urandom);
    bus.par_err     = 1'($urandom);
    bus.stp_err     = 1'($urandom);
    bus.PAR_EN      = 1'($urandom);
    bus.Prescale    = 6'($urandom);
  endtask

  // Entered at a negedge while the DUT is idle; returns at the negedge of the
  // first idle cycle after the frame (or after an injected reset).
  task automatic run_frame(input int pr, input bit pe, input int fault_in,
                           input int gap, input int rst_at);
    int p, s, t, ss, fin, c, fault;
    bit ended;
    p = (pr == 16 || pr == 32) ? pr : 8;
    fault = (fault_in == 2 && !pe) ? 0 : fault_in;
    for (int g = 0; g < gap; g++) begin
      noise();
      bus.RX_IN = 1'b1;
      @(negedge CLK);
    end
    noise();
    bus.RX_IN    = 1'b0;
    bus.PAR_EN   = pe;
    bus.Prescale = 6'(pr);
    s = cyc + 1;

    ended = 0;
    push(s + p - 2, 0, p - 2, 0, 1);
    if (fault == 1) begin
      push(s + p, 5, 0, 0, 0);
      fin = s + p;
      ended = 1;
    end else begin
      for (int k = 0; k < 8; k++) push(s + p + k * p + p - 2, 1, p - 2, k + 1, 1);
      t = s + 9 * p;
      ss = t;
      if (pe) begin
        push(t + p - 2, 2, p - 2, 9, 1);
        if (fault == 2) begin
          push(t + p, 5, 0, 0, 0);
          fin = t + p;
          ended = 1;
        end
        ss = t + p;
      end
      if (!ended) begin
        push(ss + p - 2, 3, p - 2, pe ? 10 : 9, 1);
        push(ss + p, (fault == 3) ? 5 : 4, 0, 0, 0);
        fin = ss + p;
      end
    end

    forever begin
      @(negedge CLK);
      c = cyc;
      if (c >= fin) break;
      bus.RX_IN = 1'($urandom);
      noise();
      if (c == s + p - 1) bus.strt_glitch = (fault == 1);
      if (pe && c == s + 10 * p - 1) bus.par_err = (fault == 2);
      if (!ended && c == fin - 1) bus.stp_err = (fault == 3);
      if (rst_at >= 0 && c == s + rst_at) begin
        bus.RX_IN = 1'b1;
        RST = 1'b0;
        #1;
        check_quiet("async_reset_mid_frame");
        sb.delete();
        @(negedge CLK);
        RST = 1'b1;
        return;
      end
    end
    bus.RX_IN = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish by %0t, want completion", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "timeout");
  end

  initial begin
    bus.RX_IN = 1'b1;
    noise();
    repeat (3) @(negedge CLK);
    check_quiet("reset_state");
    RST = 1'b1;
    bus.RX_IN = 1'b1;
    repeat (4) @(negedge CLK);
    check_quiet("idle_after_reset");

    run_frame(8, 1, 0, 1, -1);
    run_frame(16, 0, 0, 0, -1);
    run_frame(8, 1, 1, 2, -1);
    run_frame(8, 1, 2, 0, -1);
    run_frame(5, 1, 0, 1, -1);
    run_frame(32, 1, 3, 0, -1);
    run_frame(8, 1, 0, 2, 40);
    bus.RX_IN = 1'b1;
    repeat (5) @(negedge CLK);
    check_quiet("idle_after_midframe_reset");
    run_frame(8, 1, 0, 0, -1);

    for (int i = 0; i < 30; i++) begin
      int pr, sel, fault;
      sel = $urandom_range(0, 3);
      pr = (sel == 0) ? 8 : (sel == 1) ? 16 : (sel == 2) ? 32 : $urandom_range(0, 63);
      fault = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
      run_frame(pr, 1'($urandom), fault, $urandom_range(0, 3), -1);
    end

    bus.RX_IN = 1'b1;
    repeat (6) @(negedge CLK);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending events, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
